run_dump_ctrl: RTL and testbench



---
 rtl/run_dump_if.sv | 12 +
 rtl/run_dump_ctrl.sv | 125 ++++++++++++
 tb/tb_run_dump_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_dump_if.sv
// Valid/ready dump port carrying the register-file / data-memory index walk.
interface run_dump_if #(
   parameter int unsigned IDX_W = 10
) ();
   logic             dump_valid;
   logic             dump_ready;
   logic             dump_sel;
   logic [IDX_W-1:0] dump_idx;

   modport master (output dump_valid, output dump_sel, output dump_idx, input dump_ready);
   modport slave  (input dump_valid, input dump_sel, input dump_idx, output dump_ready);
endinterface

// File: rtl/run_dump_ctrl.sv
// Run-control and state-dump sequencer: gates the CPU, counts cycles/retires,
// enforces a watchdog, drains, then walks the register file and data memory.
module run_dump_ctrl #(
   parameter int unsigned RF_DEPTH     = 32,
   parameter int unsigned MEM_DEPTH    = 1024,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned TIMEOUT      = 1000000,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned IDX_W        = $clog2((RF_DEPTH > MEM_DEPTH) ? RF_DEPTH : MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic             retire,
   output logic             cpu_run,
   run_dump_if.master       dump,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic             timeout,
   output logic             done
);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP_RF, DUMP_MEM, DONE} state_t;

   localparam int unsigned DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   // A zero-length drain still spends one cycle in DRAIN.
   localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
   localparam logic [63:0] TO_LAST    = 64'(TIMEOUT) - 64'd1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cycle_d, instret_d;
   logic               timeout_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [IDX_W-1:0]   idx_d;
   logic               handshake_c;

   assign handshake_c = dump.dump_valid & dump.dump_ready;

   // Next-state, counter and index logic.
   always_comb begin
      state_d   = state_q;
      cycle_d   = cycle_cnt;
      instret_d = instret_cnt;
      timeout_d = timeout;
      drain_d   = drain_q;
      idx_d     = dump.dump_idx;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               cycle_d   = '0;
               instret_d = '0;
               timeout_d = 1'b0;
            end
         end
         RUN: begin
            if (cycle_cnt != '1) cycle_d = cycle_cnt + CNT_W'(1);
            if (retire && (instret_cnt != '1)) instret_d = instret_cnt + CNT_W'(1);
            drain_d = '0;
            // Halt has priority over the watchdog on the same edge.
            if (halt) begin
               state_d = DRAIN;
            end else if (64'(cycle_cnt) == TO_LAST) begin
               state_d   = DRAIN;
               timeout_d = 1'b1;
            end
         end
         DRAIN: begin
            idx_d = '0;
            if (drain_q == DRAIN_W'(DRAIN_LAST)) state_d = DUMP_RF;
            else drain_d = drain_q + DRAIN_W'(1);
         end
         DUMP_RF: begin
            if (handshake_c) begin
               if (dump.dump_idx == IDX_W'(RF_DEPTH - 1)) begin
                  state_d = DUMP_MEM;
                  idx_d   = '0;
               end else begin
                  idx_d = dump.dump_idx + IDX_W'(1);
               end
            end
         end
         DUMP_MEM: begin
            if (handshake_c) begin
               if (dump.dump_idx == IDX_W'(MEM_DEPTH - 1)) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = dump.dump_idx + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; flags are decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         drain_q         <= '0;
         cycle_cnt       <= '0;
         instret_cnt     <= '0;
         timeout         <= 1'b0;
         cpu_run         <= 1'b0;
         done            <= 1'b0;
         dump.dump_valid <= 1'b0;
         dump.dump_sel   <= 1'b0;
         dump.dump_idx   <= '0;
      end else begin
         state_q         <= state_d;
         drain_q         <= drain_d;
         cycle_cnt       <= cycle_d;
         instret_cnt     <= instret_d;
         timeout         <= timeout_d;
         cpu_run         <= (state_d == RUN);
         done            <= (state_d == DONE);
         dump.dump_valid <= (state_d == DUMP_RF) || (state_d == DUMP_MEM);
         dump.dump_sel   <= (state_d == DUMP_MEM);
         dump.dump_idx   <= idx_d;
      end
   end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: three configurations checked every cycle against a
// handshake-counting model, plus directed literal checks per scenario.
module tb_run_dump_ctrl;

   logic        clk, rst, halt, retire, ready;
   logic [2:0]  start;
   logic        run_a, run_b, run_c, to_a, to_b, to_c, done_a, done_b, done_c;
   logic [31:0] cyc_a, ret_a, cyc_b, ret_b;
   logic [3:0]  cyc_c, ret_c;

   int n_pass  = 0;
   int n_total = 0;

   run_dump_if #(.IDX_W(10)) if_a ();
   run_dump_if #(.IDX_W(3))  if_b ();
   run_dump_if #(.IDX_W(3))  if_c ();

   assign if_a.dump_ready = ready;
   assign if_b.dump_ready = ready;
   assign if_c.dump_ready = ready;

   run_dump_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start[0]), .halt(halt), .retire(retire),
      .cpu_run(run_a), .dump(if_a), .cycle_cnt(cyc_a), .instret_cnt(ret_a),
      .timeout(to_a), .done(done_a));

   run_dump_ctrl #(.RF_DEPTH(4), .MEM_DEPTH(8), .TIMEOUT(20), .DRAIN_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .start(start[1]), .halt(halt), .retire(retire),
      .cpu_run(run_b), .dump(if_b), .cycle_cnt(cyc_b), .instret_cnt(ret_b),
      .timeout(to_b), .done(done_b));

   run_dump_ctrl #(.RF_DEPTH(4), .MEM_DEPTH(8), .CNT_W(4), .DRAIN_CYCLES(2)) dut_c (
      .clk(clk), .rst(rst), .start(start[2]), .halt(halt), .retire(retire),
      .cpu_run(run_c), .dump(if_c), .cycle_cnt(cyc_c), .instret_cnt(ret_c),
      .timeout(to_c), .done(done_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observed outputs gathered per instance.
   logic            a_run[3], a_val[3], a_sel[3], a_done[3], a_to[3];
   longint unsigned a_idx[3], a_cyc[3], a_ret[3];
   always_comb begin
      a_run[0] = run_a;  a_run[1] = run_b;  a_run[2] = run_c;
      a_to[0]  = to_a;   a_to[1]  = to_b;   a_to[2]  = to_c;
      a_done[0] = done_a; a_done[1] = done_b; a_done[2] = done_c;
      a_val[0] = if_a.dump_valid; a_val[1] = if_b.dump_valid; a_val[2] = if_c.dump_valid;
      a_sel[0] = if_a.dump_sel;   a_sel[1] = if_b.dump_sel;   a_sel[2] = if_c.dump_sel;
      a_idx[0] = 64'(if_a.dump_idx); a_idx[1] = 64'(if_b.dump_idx); a_idx[2] = 64'(if_c.dump_idx);
      a_cyc[0] = 64'(cyc_a); a_cyc[1] = 64'(cyc_b); a_cyc[2] = 64'(cyc_c);
      a_ret[0] = 64'(ret_a); a_ret[1] = 64'(ret_b); a_ret[2] = 64'(ret_c);
   end

   // Model configuration: depths, effective drain length, watchdog, counter max.
   int unsigned     p_rf[3]  = '{32, 4, 4};
   int unsigned     p_mem[3] = '{1024, 8, 8};
   int              p_dm[3]  = '{4, 1, 2};
   longint unsigned p_tmo[3] = '{1000000, 20, 1000000};
   longint unsigned p_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

   // Model state: run flag, true run/retire counts, stop time, handshakes so far.
   bit              m_started[3], m_run[3], m_to[3];
   longint unsigned m_runc[3], m_ret[3];
   int              m_hs[3], m_stop[3];
   int              cyc = 0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   function automatic longint unsigned sat(input longint unsigned v, input longint unsigned m);
      return (v > m) ? m : v;
   endfunction

   function automatic bit exp_dumping(input int i);
      return m_started[i] && !m_run[i] && (m_hs[i] < int'(p_rf[i] + p_mem[i]))
             && (cyc >= m_stop[i] + p_dm[i]);
   endfunction

   function automatic bit exp_done(input int i);
      return m_started[i] && !m_run[i] && (m_hs[i] == int'(p_rf[i] + p_mem[i]));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_started[i] = 1'b0; m_run[i] = 1'b0; m_to[i] = 1'b0;
         m_runc[i] = 0; m_ret[i] = 0; m_hs[i] = 0; m_stop[i] = 0;
      end
   endtask

   task automatic model_step();
      bit hs[3];
      for (int i = 0; i < 3; i++) hs[i] = exp_dumping(i) && ready;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (!m_run[i] && (!m_started[i] || exp_done(i)) && start[i]) begin
            m_started[i] = 1'b1; m_run[i] = 1'b1; m_to[i] = 1'b0;
            m_runc[i] = 0; m_ret[i] = 0; m_hs[i] = 0;
         end else if (m_run[i]) begin
            longint unsigned shown = sat(m_runc[i], p_max[i]);
            m_runc[i]++;
            if (retire) m_ret[i]++;
            if (halt) begin
               m_run[i] = 1'b0; m_stop[i] = cyc;
            end else if (shown == p_tmo[i] - 1) begin
               m_run[i] = 1'b0; m_stop[i] = cyc; m_to[i] = 1'b1;
            end
         end else if (hs[i]) begin
            m_hs[i]++;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         bit v = exp_dumping(i);
         check($sformatf("cpu_run[%0d]", i), a_run[i], m_run[i]);
         check($sformatf("dump_valid[%0d]", i), a_val[i], v);
         check($sformatf("done[%0d]", i), a_done[i], exp_done(i));
         check($sformatf("timeout[%0d]", i), a_to[i], m_to[i]);
         check($sformatf("cycle_cnt[%0d]", i), a_cyc[i], sat(m_runc[i], p_max[i]));
         check($sformatf("instret_cnt[%0d]", i), a_ret[i], sat(m_ret[i], p_max[i]));
         if (v) begin
            bit s = (m_hs[i] >= int'(p_rf[i]));
            check($sformatf("dump_sel[%0d]", i), a_sel[i], s);
            check($sformatf("dump_idx[%0d]", i), a_idx[i],
                  longint'(s ? m_hs[i] - int'(p_rf[i]) : m_hs[i]));
         end
      end
   endtask

   // Model advances on the rising edge, outputs are compared on the falling edge.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) model_step();
         @(negedge clk);
         if (!rst) model_reset();
         compare_all();
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int n;
      rst = 1'b1; start = '0; halt = 1'b0; retire = 1'b0; ready = 1'b1;
      #1 rst = 1'b0;
      step(); step();
      check("reset_cpu_run", run_a, 0);
      check("reset_valid", if_a.dump_valid, 0);
      check("reset_cycle", cyc_a, 0);
      check("reset_done", done_a, 0);
      rst = 1'b1;
      step();

      // Halt at RUN cycle 10 with 7 retires, ready tied high.
      start[0] = 1'b1; step(); start[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         retire = (i <= 7);
         halt   = (i == 10);
         if (i == 10) check("s1_run_before_halt", run_a, 1);
         step();
      end
      halt = 1'b0; retire = 1'b1;
      check("s1_cpu_run_off", run_a, 0);
      check("s1_cycle_cnt", cyc_a, 10);
      check("s1_instret", ret_a, 7);
      check("s1_timeout", to_a, 0);
      n = 0;
      while (!if_a.dump_valid && n < 100) begin step(); n++; end
      check("s1_drain_cycles", n, 4);
      retire = 1'b0;
      n = 0;
      while (!done_a && n < 3000) begin step(); n++; end
      check("s1_done_latency", n, 1056);

      // Watchdog on the TIMEOUT=20 instance.
      start[1] = 1'b1; step(); start[1] = 1'b0; retire = 1'b1;
      n = 0;
      while (!done_b && n < 200) begin step(); n++; end
      retire = 1'b0;
      check("s2_done", done_b, 1);
      check("s2_cycle", cyc_b, 20);
      check("s2_timeout", to_b, 1);
      check("s2_instret", ret_b, 20);

      // Halt on the same edge the watchdog would fire.
      start[1] = 1'b1; step(); start[1] = 1'b0;
      check("s3_done_cleared", done_b, 0);
      for (int i = 1; i <= 20; i++) begin
         retire = (i % 2 == 0);
         halt   = (i == 20);
         step();
      end
      halt = 1'b0; retire = 1'b0;
      check("s3_cycle", cyc_b, 20);
      check("s3_timeout", to_b, 0);
      check("s3_instret", ret_b, 10);
      n = 0;
      while (!done_b && n < 200) begin step(); n++; end
      check("s3_done", done_b, 1);

      // Backpressure during the register-file walk.
      start[0] = 1'b1; step(); start[0] = 1'b0;
      for (int i = 1; i <= 3; i++) begin halt = (i == 3); step(); end
      halt = 1'b0;
      n = 0;
      while (!if_a.dump_valid && n < 100) begin step(); n++; end
      check("s4_valid", if_a.dump_valid, 1);
      repeat (5) step();
      check("s4_idx_pre", if_a.dump_idx, 5);
      ready = 1'b0; step();
      check("s4_hold1", if_a.dump_idx, 5);
      check("s4_hold1_sel", if_a.dump_sel, 0);
      step();
      check("s4_hold2", if_a.dump_idx, 5);
      ready = 1'b1; step();
      check("s4_idx_after", if_a.dump_idx, 6);
      n = 0;
      while (!done_a && n < 5000) begin ready = (n % 3 != 2); step(); n++; end
      ready = 1'b1;
      check("s4_done", done_a, 1);

      // Reset in the middle of the memory walk.
      start[0] = 1'b1; step(); start[0] = 1'b0;
      halt = 1'b1; step(); halt = 1'b0;
      n = 0;
      while (!(if_a.dump_sel && (if_a.dump_idx == 10'd300)) && n < 2000) begin step(); n++; end
      check("s5_reach_idx", if_a.dump_idx, 300);
      rst = 1'b0; #1;
      check("s5_rst_valid", if_a.dump_valid, 0);
      check("s5_rst_idx", if_a.dump_idx, 0);
      check("s5_rst_sel", if_a.dump_sel, 0);
      check("s5_rst_cycle", cyc_a, 0);
      check("s5_rst_done", done_a, 0);
      check("s5_rst_run", run_a, 0);
      step(); rst = 1'b1; step();
      start[0] = 1'b1; step(); start[0] = 1'b0;
      check("s5_restart_cycle", cyc_a, 0);
      check("s5_restart_run", run_a, 1);
      for (int i = 1; i <= 5; i++) begin halt = (i == 5); step(); end
      halt = 1'b0;
      check("s5_cycle", cyc_a, 5);
      n = 0;
      while (!done_a && n < 1200) begin step(); n++; end
      check("s5_done", done_a, 1);

      // Restart from DONE with a 3-cycle run.
      start[0] = 1'b1; step(); start[0] = 1'b0;
      check("s6_done_fell", done_a, 0);
      check("s6_cleared", cyc_a, 0);
      for (int i = 1; i <= 3; i++) begin retire = 1'b1; halt = (i == 3); step(); end
      halt = 1'b0; retire = 1'b0;
      check("s6_cycle", cyc_a, 3);
      check("s6_instret", ret_a, 3);
      n = 0;
      while (!done_a && n < 1200) begin step(); n++; end
      check("s6_done", done_a, 1);

      // 4-bit counters saturate on a 20-cycle run.
      start[2] = 1'b1; step(); start[2] = 1'b0;
      for (int i = 1; i <= 20; i++) begin retire = 1'b1; halt = (i == 20); step(); end
      halt = 1'b0; retire = 1'b0;
      check("s7_cycle_sat", cyc_c, 15);
      check("s7_instret_sat", ret_c, 15);
      check("s7_timeout", to_c, 0);
      n = 0;
      while (!done_c && n < 100) begin step(); n++; end
      check("s7_done", done_c, 1);
      halt = 1'b1;
      repeat (3) step();
      check("s7_no_retrigger_done", done_c, 1);
      check("s7_no_retrigger_run", run_c, 0);
      halt = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
